// File: rtl/uart_cmd_wrapper.sv
// Host-side UART front end: assembles received byte pairs into 16-bit commands
// and serialises 8-bit responses back to the host.
`timescale 1ns/1ps
module uart_cmd_wrapper #(
    parameter int unsigned MIN_BAUD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] baud_cnt,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam logic [15:0] MinBaud = 16'(MIN_BAUD);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {WaitHi, WaitLo} asm_state_e;
    typedef enum logic {TxIdle, TxXmit} tx_state_e;

    logic [15:0] baud_clamped;
    assign baud_clamped = (baud_cnt < MinBaud) ? MinBaud : baud_cnt;

    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_baud_q, rx_baud_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        start_det, rx_byte_vld, rx_frame_err;
    logic        rx_tick, rx_half_tick;

    asm_state_e  asm_q, asm_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_baud_q, tx_baud_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic        resp_sent_q, resp_sent_d;
    logic        tx_tick;

    assign rx_tick      = (rx_cnt_q == rx_baud_q - 16'd1);
    assign rx_half_tick = (rx_cnt_q == (rx_baud_q >> 1) - 16'd1);

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_baud_d    = rx_baud_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        start_det    = 1'b0;
        rx_byte_vld  = 1'b0;
        rx_frame_err = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    start_det  = 1'b1;
                    rx_baud_d  = baud_clamped;
                    rx_cnt_d   = 16'd0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_half_tick) begin
                    rx_cnt_d = 16'd0;
                    rx_bit_d = 4'd0;
                    // A high line at mid-start means the falling edge was a glitch
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (rx_tick) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (rx_tick) begin
                    rx_cnt_d     = 16'd0;
                    rx_state_d   = RxIdle;
                    rx_byte_vld  = rx_sync_q;
                    rx_frame_err = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        asm_d     = asm_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy || start_det) begin
            cmd_rdy_d = 1'b0;
        end
        // Placed after the clear so a coincident set takes priority
        if (rx_byte_vld) begin
            if (asm_q == WaitHi) begin
                cmd_d[15:8] = rx_shift_q;
                asm_d       = WaitLo;
            end else begin
                cmd_d[7:0] = rx_shift_q;
                cmd_rdy_d  = 1'b1;
                asm_d      = WaitHi;
            end
        end else if (rx_frame_err) begin
            asm_d = WaitHi;
        end
    end

    assign tx_tick = (tx_cnt_q == tx_baud_q - 16'd1);

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_baud_d   = tx_baud_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        resp_sent_d = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                if (send_resp) begin
                    tx_shift_d = {1'b1, resp, 1'b0};
                    tx_baud_d  = baud_clamped;
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 4'd0;
                    tx_state_d = TxXmit;
                end
            end
            TxXmit: begin
                if (tx_tick) begin
                    tx_cnt_d   = 16'd0;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'd9) begin
                        resp_sent_d = 1'b1;
                        tx_state_d  = TxIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_baud_q   <= MinBaud;
            rx_cnt_q    <= 16'd0;
            rx_bit_q    <= 4'd0;
            rx_shift_q  <= 8'd0;
            asm_q       <= WaitHi;
            cmd_q       <= 16'h0000;
            cmd_rdy_q   <= 1'b0;
            tx_state_q  <= TxIdle;
            tx_baud_q   <= MinBaud;
            tx_cnt_q    <= 16'd0;
            tx_bit_q    <= 4'd0;
            tx_shift_q  <= '1;
            resp_sent_q <= 1'b0;
        end else begin
            rx_meta_q   <= RX;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            asm_q       <= asm_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_state_q  <= tx_state_d;
            tx_baud_q   <= tx_baud_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // Shift register resets to all ones, so TX goes idle-high with reset
    assign TX        = tx_shift_q[0];
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed bench for uart_cmd_wrapper: table-driven command and response frames
// plus hand-written glitch, framing, full-duplex and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_cmd_wrapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] baud_cnt;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    int errors = 0;
    int checks = 0;

    uart_cmd_wrapper #(.MIN_BAUD(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .baud_cnt    (baud_cnt),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] baud_in;
        int          b;
    } cmd_vec_t;

    typedef struct {
        logic [7:0]  rsp;
        logic [15:0] baud_in;
        int          b;
        int          extra_at;
    } tx_vec_t;

    // Drives one frame starting at the next falling clock edge; b clocks per bit.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int b);
        @(negedge clk);
        RX = 1'b0;
        repeat (b) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (b) @(negedge clk);
        end
        RX = stop;
        repeat (b) @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Second byte is driven inline so cmd_rdy can be checked around the stop sample,
    // which lands b/2+2 cycles into the stop bit (2 synchroniser cycles).
    task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo, input int b,
                            input bit clr_at_accept);
        logic [15:0] exp_cmd;
        exp_cmd = {hi, lo};
        send_byte(hi, 1'b1, b);
        @(negedge clk);
        RX = 1'b0;
        repeat (b) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = lo[i];
            repeat (b) @(negedge clk);
        end
        RX = 1'b1;
        repeat (b / 2 + 2) @(negedge clk);
        chk("cmd_rdy_at_stop_sample", {31'd0, cmd_rdy}, 32'd0);
        if (clr_at_accept) clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_after_stop_sample", {31'd0, cmd_rdy}, 32'd1);
        chk("cmd_value", {16'd0, cmd}, {16'd0, exp_cmd});
        repeat (b - b / 2 - 3) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    // Pulses send_resp and checks TX / resp_sent every cycle of the frame.
    task automatic tx_frame(input logic [7:0] r, input int b, input int extra_at);
        logic [9:0]  frame;
        logic        exp_tx;
        logic [15:0] saved_baud;
        frame      = {1'b1, r, 1'b0};
        saved_baud = baud_cnt;
        @(negedge clk);
        resp      = r;
        send_resp = 1'b1;
        for (int c = 1; c <= 10 * b + 1; c++) begin
            @(negedge clk);
            if (c == 1 || c == extra_at + 1) send_resp = 1'b0;
            exp_tx = (c <= 10 * b) ? frame[(c - 1) / b] : 1'b1;
            chk($sformatf("tx_bit_c%0d", c), {31'd0, TX}, {31'd0, exp_tx});
            chk($sformatf("resp_sent_c%0d", c), {31'd0, resp_sent},
                {31'd0, (c == 10 * b + 1)});
            if (c == extra_at) begin
                send_resp = 1'b1;
                resp      = ~r;
                baud_cnt  = baud_cnt + 16'd24;
            end
        end
        @(negedge clk);
        chk("resp_sent_single_pulse", {31'd0, resp_sent}, 32'd0);
        baud_cnt = saved_baud;
    endtask

    cmd_vec_t cvecs[4];
    tx_vec_t  tvecs[3];

    initial begin
        cvecs[0] = '{hi: 8'h41, lo: 8'h2A, baud_in: 16'd16, b: 16};
        cvecs[1] = '{hi: 8'hFF, lo: 8'h00, baud_in: 16'd16, b: 16};
        cvecs[2] = '{hi: 8'h5A, lo: 8'hC3, baud_in: 16'd20, b: 20};
        cvecs[3] = '{hi: 8'h81, lo: 8'h7E, baud_in: 16'd4,  b: 16};
        tvecs[0] = '{rsp: 8'hA5, baud_in: 16'd16, b: 16, extra_at: 50};
        tvecs[1] = '{rsp: 8'h3C, baud_in: 16'd20, b: 20, extra_at: 0};
        tvecs[2] = '{rsp: 8'h01, baud_in: 16'd4,  b: 16, extra_at: 0};

        rst_n       = 1'b0;
        RX          = 1'b1;
        baud_cnt    = 16'd16;
        clr_cmd_rdy = 1'b0;
        resp        = 8'h00;
        send_resp   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, TX}, 32'd1);
        chk("reset_cmd", {16'd0, cmd}, 32'd0);
        chk("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("reset_resp_sent", {31'd0, resp_sent}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            baud_cnt = cvecs[k].baud_in;
            send_cmd(cvecs[k].hi, cvecs[k].lo, cvecs[k].b, 1'b0);
            repeat (2) @(negedge clk);
            chk($sformatf("cmd_rdy_held_v%0d", k), {31'd0, cmd_rdy}, 32'd1);
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            chk($sformatf("cmd_rdy_cleared_v%0d", k), {31'd0, cmd_rdy}, 32'd0);
            chk($sformatf("cmd_kept_v%0d", k), {16'd0, cmd},
                {16'd0, cvecs[k].hi, cvecs[k].lo});
        end

        for (int k = 0; k < 3; k++) begin
            baud_cnt = tvecs[k].baud_in;
            tx_frame(tvecs[k].rsp, tvecs[k].b, tvecs[k].extra_at);
        end
        baud_cnt = 16'd16;

        // Glitch: a short low pulse clears cmd_rdy but must not advance the assembler
        send_cmd(8'hA1, 8'hB2, 16, 1'b0);
        @(negedge clk);
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("glitch_cmd_kept", {16'd0, cmd}, 32'h0000_A1B2);
        send_cmd(8'h77, 8'h88, 16, 1'b0);

        // Framing error on the low byte drops the partial command
        send_byte(8'h12, 1'b1, 16);
        send_byte(8'h55, 1'b0, 16);
        repeat (4) @(negedge clk);
        chk("framing_no_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        send_cmd(8'hC0, 8'h03, 16, 1'b0);

        // Full duplex, with a clear coincident with the low-byte acceptance
        fork
            tx_frame(8'hEE, 16, 0);
            send_cmd(8'h9C, 8'h35, 16, 1'b1);
        join
        chk("duplex_set_wins", {31'd0, cmd_rdy}, 32'd1);
        chk("duplex_cmd", {16'd0, cmd}, 32'h0000_9C35);

        // Mid-frame reset during bit 4 of both a TX and an RX frame
        @(negedge clk);
        resp      = 8'h00;
        send_resp = 1'b1;
        RX        = 1'b0;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (4 * 16 + 6) @(negedge clk);
        chk("pre_reset_tx_low", {31'd0, TX}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_tx", {31'd0, TX}, 32'd1);
        chk("reset_mid_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("reset_mid_cmd", {16'd0, cmd}, 32'd0);
        RX = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_tx_idle", {31'd0, TX}, 32'd1);
        send_cmd(8'h3E, 8'hD1, 16, 1'b0);
        chk("post_reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
